// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared constants and FSM encoding for the SDRAM arbiter.
//   ADDR_W_DEF     default SDRAM word-address width
//   DATA_W_DEF     default command/read data width
//   RD_TIMEOUT_DEF default read-data wait limit in cycles
package sdram_arb_pkg;

   localparam int unsigned ADDR_W_DEF     = 23;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned RD_TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: requester ports 0/1, controller command/read-data side
// and the timeout status flag of the SDRAM arbiter.
//   slave  : arbiter view (requests/controller status in, acks/command out)
//   master : environment view (requesters plus SDRAM controller)
interface sdram_arbiter_if
   import sdram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic              r0_req;
   logic              r0_wr;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic              r0_ack;
   logic [DATA_W-1:0] r0_rdata;
   logic              r0_rvalid;

   logic              r1_req;
   logic              r1_wr;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_ack;
   logic [DATA_W-1:0] r1_rdata;
   logic              r1_rvalid;

   logic              mem_cmd_ready;
   logic              mem_cmd_enable;
   logic              mem_cmd_wr;
   logic [ADDR_W-1:0] mem_cmd_address;
   logic [DATA_W-1:0] mem_cmd_data_in;
   logic [DATA_W-1:0] mem_data_out;
   logic              mem_data_out_ready;

   logic              rd_timeout_err;

   modport slave (
      input  r0_req, r0_wr, r0_addr, r0_wdata,
      output r0_ack, r0_rdata, r0_rvalid,
      input  r1_req, r1_wr, r1_addr, r1_wdata,
      output r1_ack, r1_rdata, r1_rvalid,
      input  mem_cmd_ready, mem_data_out, mem_data_out_ready,
      output mem_cmd_enable, mem_cmd_wr, mem_cmd_address, mem_cmd_data_in,
      output rd_timeout_err
   );

   modport master (
      output r0_req, r0_wr, r0_addr, r0_wdata,
      input  r0_ack, r0_rdata, r0_rvalid,
      output r1_req, r1_wr, r1_addr, r1_wdata,
      input  r1_ack, r1_rdata, r1_rvalid,
      output mem_cmd_ready, mem_data_out, mem_data_out_ready,
      input  mem_cmd_enable, mem_cmd_wr, mem_cmd_address, mem_cmd_data_in,
      input  rd_timeout_err
   );

endinterface

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin selector.
//   clk, rst  clock and synchronous active-low reset
//   req       request vector (bit n = port n)
//   take      grant is being taken this cycle; remember the winner
//   any_c     at least one request present (combinational)
//   winner_c  index of the winning port (combinational)
module arb_rr2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic       any_c,
   output logic       winner_c
);

   logic last_q;

   // Sole requester wins; on a tie the port not granted last wins.
   always_comb begin
      any_c    = |req;
      winner_c = 1'b0;
      case (req)
         2'b01:   winner_c = 1'b0;
         2'b10:   winner_c = 1'b1;
         2'b11:   winner_c = ~last_q;
         default: winner_c = 1'b0;
      endcase
   end

   // Pointer starts at 1 so port 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_q <= 1'b1;
      end else if (take) begin
         last_q <= winner_c;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller command port between the
// sampler writer (port 0) and the dump reader (port 1), one command at a time.
//   clk  100 MHz SDRAM-domain clock
//   rst  synchronous active-low reset
//   bus  requester ports, controller command/read-data side, timeout flag
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned RD_TIMEOUT = RD_TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   sdram_arbiter_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

   arb_state_e        state_q, state_d;

   logic              owner_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              cmd_en_q;
   logic [1:0]        ack_q;
   logic [1:0]        rvalid_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              arb_any_c;
   logic              arb_winner_c;
   logic              grant_c;
   logic              accept_c;
   logic              rd_done_c;
   logic              timeout_c;
   logic [CNT_W-1:0]  cnt_nxt_c;

   arb_rr2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      ({bus.r1_req, bus.r0_req}),
      .take     (grant_c),
      .any_c    (arb_any_c),
      .winner_c (arb_winner_c)
   );

   // Saturating wait counter value for the next WAIT_RD cycle.
   assign cnt_nxt_c = (cnt_q == CNT_W'(RD_TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-cycle events.
   always_comb begin
      state_d   = state_q;
      grant_c   = 1'b0;
      accept_c  = 1'b0;
      rd_done_c = 1'b0;
      timeout_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_any_c && bus.mem_cmd_ready) begin
               grant_c = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_en_q && bus.mem_cmd_ready) begin
               accept_c = 1'b1;
               state_d  = wr_q ? IDLE : WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (bus.mem_data_out_ready) begin
               rd_done_c = 1'b1;
               state_d   = IDLE;
            end else if (cnt_nxt_c == CNT_W'(RD_TIMEOUT)) begin
               timeout_c = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered command fields, handshakes, read data and status.
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q  <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cmd_en_q <= 1'b0;
         ack_q    <= '0;
         rvalid_q <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         cmd_en_q <= (state_d == ISSUE);
         ack_q    <= '0;
         rvalid_q <= '0;
         if (grant_c) begin
            owner_q <= arb_winner_c;
            wr_q    <= arb_winner_c ? bus.r1_wr    : bus.r0_wr;
            addr_q  <= arb_winner_c ? bus.r1_addr  : bus.r0_addr;
            wdata_q <= arb_winner_c ? bus.r1_wdata : bus.r0_wdata;
         end
         if (accept_c) begin
            ack_q[owner_q] <= 1'b1;
            cnt_q          <= '0;
         end else if (state_q == WAIT_RD) begin
            cnt_q <= cnt_nxt_c;
         end
         if (rd_done_c) begin
            rvalid_q[owner_q] <= 1'b1;
            if (owner_q) begin
               rdata1_q <= bus.mem_data_out;
            end else begin
               rdata0_q <= bus.mem_data_out;
            end
         end
         if (timeout_c) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.mem_cmd_enable  = cmd_en_q;
   assign bus.mem_cmd_wr      = wr_q;
   assign bus.mem_cmd_address = addr_q;
   assign bus.mem_cmd_data_in = wdata_q;
   assign bus.r0_ack          = ack_q[0];
   assign bus.r1_ack          = ack_q[1];
   assign bus.r0_rvalid       = rvalid_q[0];
   assign bus.r1_rvalid       = rvalid_q[1];
   assign bus.r0_rdata        = rdata0_q;
   assign bus.r1_rdata        = rdata1_q;
   assign bus.rd_timeout_err  = err_q;

endmodule
